// File: rtl/irq_controller_if.sv
// Core <-> interrupt controller bundle: exception/IRQ inputs, mask writes, redirect and EPC/Cause.
// No latency of its own; pure wiring between core and controller.
// No backpressure: every signal is a per-cycle level or strobe.
interface irq_controller_if #(
    parameter int NIRQ = 3
);
    logic [31:0]     PC;
    logic            ErrInst;
    logic            Ovf;
    logic [NIRQ-1:0] Irq;
    logic            Eret;
    logic            MaskWr;
    logic [NIRQ-1:0] MaskIn;
    logic            Take;
    logic [31:0]     TakePC;
    logic [31:0]     EPC;
    logic [31:0]     Cause;
    logic [NIRQ-1:0] Pending;
    logic [NIRQ-1:0] Mask;
    logic            InService;

    // Core side drives execution status and consumes the redirect.
    modport master (
        output PC, ErrInst, Ovf, Irq, Eret, MaskWr, MaskIn,
        input  Take, TakePC, EPC, Cause, Pending, Mask, InService
    );

    // Controller side.
    modport slave (
        input  PC, ErrInst, Ovf, Irq, Eret, MaskWr, MaskIn,
        output Take, TakePC, EPC, Cause, Pending, Mask, InService
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt/exception scheduler: latches IRQ edges, masks, prioritises, redirects PC to VECTOR.
// Take is combinational (zero latency); EPC/Cause/Pending/Mask update on the following edge.
// No backpressure; nesting is blocked in SERVICE until Eret returns the controller to IDLE.
module irq_controller #(
    parameter int          NIRQ    = 3,
    parameter logic [31:0] VECTOR  = 32'h8000_0008,
    parameter logic [31:0] EPC_RST = 32'h8000_0000
) (
    input  logic C,
    input  logic R,
    irq_controller_if.slave bus
);
    typedef enum logic {IDLE, SERVICE} state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] irq_prev_q;
    logic [31:0]     epc_q, epc_d;
    logic [31:0]     cause_q, cause_d;
    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] elig;
    logic [NIRQ-1:0] pend_clr;
    logic [31:0]     win_cause;
    logic            take;

    assign irq_edge = bus.Irq & ~irq_prev_q;
    assign elig     = pending_q & ~mask_q;
    assign mask_d   = bus.MaskWr ? bus.MaskIn : mask_q;

    // Winner select: exceptions first, then lowest-numbered eligible IRQ (loop runs high to low so the lowest index wins).
    always_comb begin
        win_cause = '0;
        pend_clr  = '0;
        if (bus.ErrInst) begin
            win_cause[0] = 1'b1;
        end else if (bus.Ovf) begin
            win_cause[1] = 1'b1;
        end else begin
            for (int i = NIRQ - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    win_cause        = '0;
                    win_cause[2 + i] = 1'b1;
                    pend_clr         = '0;
                    pend_clr[i]      = 1'b1;
                end
            end
        end
    end

    // Next-state and redirect: new edges always set Pending, and a set beats the winner's clear.
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pending_d = pending_q | irq_edge;
        case (state_q)
            IDLE: begin
                take = ~bus.PC[31] & (bus.ErrInst | bus.Ovf | (|elig));
                if (take) begin
                    state_d   = SERVICE;
                    epc_d     = bus.PC;
                    cause_d   = win_cause;
                    pending_d = (pending_q & ~pend_clr) | irq_edge;
                end
            end
            SERVICE: begin
                // Fault inside the handler: flag it stickily, never redirect.
                if (bus.ErrInst | bus.Ovf) begin
                    cause_d[31] = 1'b1;
                end
                if (bus.Eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards pending events and restores EPC/Cause.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            epc_q      <= EPC_RST;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= bus.Irq;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.Take      = take;
    assign bus.TakePC    = VECTOR;
    assign bus.EPC       = epc_q;
    assign bus.Cause     = cause_q;
    assign bus.Pending   = pending_q;
    assign bus.Mask      = mask_q;
    assign bus.InService = (state_q == SERVICE);
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt/exception scheduler for the single-cycle MIPS32 core.
- Takes synchronous exceptions (illegal instruction, arithmetic overflow) and peripheral interrupt requests (timer overflow, UART Rx ready, UART Tx ready). Latches, masks and prioritises them.
- Tells the PC logic when to redirect to the handler vector and supplies EPC/Cause.
- Blocks nesting until the handler returns (Eret).

Parameters:
- NIRQ, 3: number of peripheral interrupt inputs (bit 0 = timer, 1 = Rx, 2 = Tx).
- VECTOR, 32'h8000_0008: handler entry address driven on TakePC.
- EPC_RST, 32'h8000_0000: reset value of EPC.

Ports:
- C  input  1  clock; all state updates on rising edge.
- R  input  1  reset; asynchronous, active-high.
- PC  input  32  PC of the instruction executing this cycle; PC[31]=1 means kernel mode.
- ErrInst  input  1  illegal opcode/funct for the current instruction (level, this cycle only).
- Ovf  input  1  ALU overflow with overflow trapping enabled for the current instruction.
- Irq  input  NIRQ  peripheral request levels; a rising edge is an event.
- Eret  input  1  handler-return strobe, one cycle.
- MaskWr  input  1  write enable for the mask register.
- MaskIn  input  NIRQ  new mask value; 1 = masked.
- Take  output  1  redirect this cycle: PC <= TakePC, and the core suppresses RegWr/MemWr.
- TakePC  output  32  constant VECTOR.
- EPC  output  32  saved PC of the interrupted instruction.
- Cause  output  32  cause record.
- Pending  output  NIRQ  latched unserviced interrupts.
- Mask  output  NIRQ  current mask.
- InService  output  1  1 while in the SERVICE state.

Behaviour:
- Reset (R=1, async) sets:
  - state IDLE, Take=0, InService=0
  - Pending=0, Mask=0 (all enabled), IrqPrev=0
  - EPC=EPC_RST, Cause=0
- Edge detect: IrqPrev registers Irq each cycle. Pending[i] is set when Irq[i]&~IrqPrev[i]. A level held high gives exactly one event.
- Eligibility: Elig = Pending & ~Mask. Exceptions are never maskable.
- Priority, highest first: ErrInst, Ovf, Irq[0], Irq[1], ... Irq[NIRQ-1].
- State IDLE:
  - Take = ~PC[31] & (ErrInst | Ovf | |Elig). Combinational, same cycle, zero latency.
  - On an edge with Take=1:
    - EPC <= PC.
    - Cause <= one-hot of the winning source in bits [NIRQ+1:0]: bit0 ErrInst, bit1 Ovf, bit2+i Irq[i]; all other bits 0.
    - If the winner is Irq[i], clear Pending[i].
    - state <= SERVICE.
  - When PC[31]=1 in IDLE (kernel code running outside a handler): Take=0; pending bits are held.
- State SERVICE:
  - Take=0, InService=1.
  - New edges still set Pending; nothing is taken.
  - ErrInst or Ovf seen in SERVICE sets Cause[31] (nested-fault flag, sticky). No redirect.
  - Eret=1 -> state IDLE on the next edge. Earliest new Take is the cycle after that edge, never the Eret cycle itself.
- Eret in IDLE: ignored.
- Simultaneous events:
  - Set and clear of the same Pending bit in one cycle: set wins, bit stays 1 (new event).
  - MaskWr takes effect on the next edge; Elig in the write cycle uses the old Mask.
  - Masking a pending bit keeps it pending; unmasking later makes it eligible.
- EPC/Cause change only on Take edges (plus the Cause[31] set). They are readable by the core as ALU operands at any time.
- Reset mid-SERVICE: returns to IDLE and discards all pending events.

Test Plan:
- Reset then idle, PC=32'h0000_0040, all inputs 0 -> Take=0, EPC=32'h8000_0000, Cause=0, Mask=0.
- ErrInst=1 at PC=32'h0000_0100 -> Take=1 same cycle. Next cycle EPC=32'h0000_0100, Cause=32'h1, InService=1.
- Irq=3'b110 rising together at PC=32'h0000_0200:
  - Take next cycle (pending registered), Cause=32'h8 (Rx), Pending=3'b100.
  - After Eret plus one idle cycle, second Take with Cause=32'h10.
- Mask=3'b001 and timer edge -> Pending=3'b001, Take=0. Write Mask=0 -> Take asserted on the following cycle, Cause=32'h4.
- In SERVICE, Ovf=1 and Irq[0] edge -> no Take, Cause[31]=1, Pending[0]=1. Eret -> IDLE, then Take with Cause=32'h4.
- Irq[1] held high for 10 cycles, kernel PC=32'h8000_0010 in IDLE -> Take=0 throughout. Switch PC to 32'h0000_0010 -> exactly one Take, none repeated after Eret.
- Assert R in SERVICE with Pending=3'b011 -> immediately state IDLE, Pending=0, Cause=0, EPC=32'h8000_0000.
